multi_tick_timer: RTL and testbench

MULTI_TICK_TIMER -- requirements
Module: multi_tick_timer

---
 rtl/multi_tick_timer.sv | 135 +++++++++++++
 tb/tb_multi_tick_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_timer.sv
// multi_tick_timer: NUM_CH independent up-counting timers sharing one clock.
// Each channel counts steps up to its period, pulses tick for one cycle on
// expiry, and in one-shot mode latches done until it is cleared.
// Optional feature: define MULTI_TICK_TIMER_PRESCALE_EN to add a shared
// prescaler so counters only step every PRESCALE pclk cycles.

module multi_tick_timer #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_WIDTH = 30,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             ch_clr,
    input  logic [NUM_CH-1:0]             ch_oneshot,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   ch_period,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             done,
    output logic                          tick_any
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // A zero prescale has no meaning; this empty block only exists so the
    // parameter is always referenced, even when the prescaler is compiled out.
    if (PRESCALE == 0) begin : g_prescaleZero
    end

    logic stepStrobe;

`ifdef MULTI_TICK_TIMER_PRESCALE_EN
    localparam int unsigned     PscWidth = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PscWidth-1:0] PscLast  = PscWidth'(PRESCALE - 1);
    localparam logic [PscWidth-1:0] PscOne   = PscWidth'(1);

    logic [PscWidth-1:0] psc_q;
    logic [PscWidth-1:0] psc_d;

    assign stepStrobe = (psc_q == PscLast);

    // Free-running prescaler: restart after the strobe cycle.
    always_comb begin
        psc_d = stepStrobe ? '0 : (psc_q + PscOne);
    end

    // Prescaler register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign stepStrobe = 1'b1;
`endif

    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] shadow_q;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] shadow_d;
    logic [NUM_CH-1:0]                tick_q;
    logic [NUM_CH-1:0]                tick_d;
    logic [NUM_CH-1:0]                done_q;
    logic [NUM_CH-1:0]                done_d;
    logic                             tickAny_q;

    // Per-channel next state. While the counter sits at 0 the live ch_period
    // is the period in force, so a fresh count always uses the newest value;
    // once counting has started only the shadow copy matters until the wrap.
    always_comb begin
        logic [CNT_WIDTH-1:0] periodIn;
        logic [CNT_WIDTH-1:0] effPeriod;
        logic                 advance;

        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        tick_d    = '0;
        done_d    = done_q;
        periodIn  = '0;
        effPeriod = '0;
        advance   = 1'b0;

        for (int i = 0; i < int'(NUM_CH); i++) begin
            periodIn  = ch_period[i*CNT_WIDTH +: CNT_WIDTH];
            effPeriod = (cnt_q[i] == '0) ? periodIn : shadow_q[i];
            advance   = stepStrobe && ch_en[i] && !done_q[i] && (effPeriod != '0);

            if (ch_clr[i]) begin
                cnt_d[i]    = '0;
                done_d[i]   = 1'b0;
                shadow_d[i] = periodIn;
            end else if (advance) begin
                if (cnt_q[i] == (effPeriod - CntOne)) begin
                    cnt_d[i]    = '0;
                    tick_d[i]   = 1'b1;
                    shadow_d[i] = periodIn;
                    if (ch_oneshot[i]) begin
                        done_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                    if (cnt_q[i] == '0) begin
                        shadow_d[i] = periodIn;
                    end
                end
            end else if (cnt_q[i] == '0) begin
                shadow_d[i] = periodIn;
            end
        end
    end

    // Channel state, tick pulses and the combined tick flag.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q     <= '0;
            shadow_q  <= '0;
            tick_q    <= '0;
            done_q    <= '0;
            tickAny_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            tickAny_q <= |tick_d;
        end
    end

    assign tick     = tick_q;
    assign done     = done_q;
    assign tick_any = tickAny_q;

endmodule

// File: tb/tb_multi_tick_timer.sv
// Testbench for multi_tick_timer: directed scenarios followed by random
// traffic, checked cycle by cycle against a step-counting reference model.

module tb_multi_tick_timer;

    localparam int NumCh    = 2;
    localparam int CntWidth = 8;
`ifdef MULTI_TICK_TIMER_PRESCALE_EN
    localparam int DutPrescale   = 4;
    localparam int ModelPrescale = 4;
`else
    localparam int DutPrescale   = 3;
    localparam int ModelPrescale = 1;
`endif

    typedef struct packed {
        logic [NumCh-1:0] tick;
        logic [NumCh-1:0] done;
        logic             any;
    } expect_t;

    logic                      pclk = 1'b0;
    logic                      presetn = 1'b0;
    logic [NumCh-1:0]          ch_en = '0;
    logic [NumCh-1:0]          ch_clr = '0;
    logic [NumCh-1:0]          ch_oneshot = '0;
    logic [NumCh*CntWidth-1:0] ch_period = '0;
    logic [NumCh-1:0]          tick;
    logic [NumCh-1:0]          done;
    logic                      tick_any;

    expect_t     expectQ[$];
    int          vectors = 0;
    int          miscompares = 0;

    logic [NumCh-1:0] enV = '0;
    logic [NumCh-1:0] clrV = '0;
    logic [NumCh-1:0] osV = '0;
    logic             rstnV = 1'b0;
    int unsigned      periodV[NumCh];

    int unsigned elapsed[NumCh];
    int unsigned curP[NumCh];
    bit          mDone[NumCh];
    int unsigned cyclesSinceReset;

    multi_tick_timer #(
        .NUM_CH(NumCh),
        .CNT_WIDTH(CntWidth),
        .PRESCALE(DutPrescale)
    ) dut (
        .pclk(pclk),
        .presetn(presetn),
        .ch_en(ch_en),
        .ch_clr(ch_clr),
        .ch_oneshot(ch_oneshot),
        .ch_period(ch_period),
        .tick(tick),
        .done(done),
        .tick_any(tick_any)
    );

    always #5 pclk = ~pclk;

    function automatic void resetModel();
        for (int c = 0; c < NumCh; c++) begin
            elapsed[c] = 0;
            curP[c]    = 0;
            mDone[c]   = 1'b0;
        end
        cyclesSinceReset = 0;
    endfunction

    // Reference: count steps since the interval started; the period is
    // latched when an interval takes its first step; expiry when the step
    // count reaches that period.
    function automatic expect_t modelStep();
        expect_t e;
        bit      strobe;
        e = '0;
        if (!rstnV) begin
            resetModel();
            return e;
        end
        strobe = ((cyclesSinceReset % ModelPrescale) == (ModelPrescale - 1));
        cyclesSinceReset++;
        for (int c = 0; c < NumCh; c++) begin
            if (clrV[c]) begin
                elapsed[c] = 0;
                mDone[c]   = 1'b0;
            end else if (strobe && enV[c] && !mDone[c]) begin
                if (elapsed[c] == 0) curP[c] = periodV[c];
                if (curP[c] != 0) begin
                    elapsed[c]++;
                    if (elapsed[c] == curP[c]) begin
                        e.tick[c]  = 1'b1;
                        elapsed[c] = 0;
                        if (osV[c]) mDone[c] = 1'b1;
                    end
                end
            end
            e.done[c] = mDone[c];
        end
        e.any = |e.tick;
        return e;
    endfunction

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge pclk);
            ch_en      = enV;
            ch_clr     = clrV;
            ch_oneshot = osV;
            for (int c = 0; c < NumCh; c++) begin
                ch_period[c*CntWidth +: CntWidth] = CntWidth'(periodV[c]);
            end
            presetn = rstnV;
            expectQ.push_back(modelStep());
        end
    endtask

    task automatic compareField(input string name, input logic [NumCh-1:0] got,
                                input logic [NumCh-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        compareField("tick", tick, e.tick);
        compareField("done", done, e.done);
        compareField("tick_any", NumCh'(tick_any), NumCh'(e.any));
    endtask

    // Asynchronous reset mid-cycle: outputs must drop without waiting for a clock edge.
    task automatic asyncResetCheck();
        @(negedge pclk);
        #1;
        presetn = 1'b0;
        rstnV   = 1'b0;
        #1;
        compareField("async_rst_tick", tick, '0);
        compareField("async_rst_done", done, '0);
        compareField("async_rst_any", NumCh'(tick_any), '0);
        resetModel();
    endtask

    // Monitor: one expected response per clock, compared just after the edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge pclk);
            #1;
            if (expectQ.size() > 0) begin
                e = expectQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic.
    initial begin
        for (int c = 0; c < NumCh; c++) periodV[c] = 0;
        resetModel();

        rstnV = 1'b0;
        applyStimulus(3);
        rstnV = 1'b1;

        $display("[TB] periodic P=5 on ch0, one-shot P=3 on ch1");
        periodV[0] = 5; periodV[1] = 3;
        osV = 2'b10; enV = 2'b11;
        applyStimulus(20);
        clrV = 2'b10;
        applyStimulus(1);
        clrV = 2'b00;
        applyStimulus(8);

        $display("[TB] mid-count enable drop and period change");
        osV = 2'b00; enV = 2'b00; clrV = 2'b11;
        periodV[0] = 10;
        applyStimulus(1);
        clrV = 2'b00; enV = 2'b01;
        applyStimulus(4);
        enV = 2'b00;
        applyStimulus(7);
        enV = 2'b01;
        applyStimulus(2);
        periodV[0] = 4;
        applyStimulus(20);

        $display("[TB] P=1 and P=0");
        periodV[0] = 1; periodV[1] = 0; enV = 2'b11;
        clrV = 2'b11;
        applyStimulus(1);
        clrV = 2'b00;
        applyStimulus(50);

        $display("[TB] clear and enable together");
        periodV[0] = 2; periodV[1] = 2; clrV = 2'b11;
        applyStimulus(5);
        clrV = 2'b00;
        applyStimulus(6);

        $display("[TB] reset mid-count");
        clrV = 2'b11; applyStimulus(1);
        clrV = 2'b00; periodV[0] = 10; periodV[1] = 0; enV = 2'b01;
        applyStimulus(7);
        asyncResetCheck();
        applyStimulus(2);
        rstnV = 1'b1;
        applyStimulus(25);

        $display("[TB] largest period and simultaneous ticks");
        periodV[0] = (1 << CntWidth) - 1; clrV = 2'b11; applyStimulus(1);
        clrV = 2'b00;
        applyStimulus(520);
        periodV[0] = 3; periodV[1] = 3; enV = 2'b11; clrV = 2'b11;
        applyStimulus(1);
        clrV = 2'b00;
        applyStimulus(30);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NumCh; c++) begin
                if ($urandom_range(0, 15) == 0) periodV[c] = $urandom_range(0, 7);
                enV[c]  = ($urandom_range(0, 7) != 0);
                clrV[c] = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 29) == 0) osV[c] = ~osV[c];
            end
            rstnV = ($urandom_range(0, 399) != 0);
            applyStimulus(1);
        end
        rstnV = 1'b1;
        applyStimulus(2);

        @(posedge pclk);
        #3;
        vectors++;
        if (expectQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expectQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
